// File: rtl/ttt_turn_controller_if.sv
// ttt_turn_controller_if: player-choice inputs and board/status outputs of the turn controller.
interface ttt_turn_controller_if;
    logic [3:0]  choice;
    logic        new_game;
    logic [17:0] board;
    logic        turn;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;
    modport master (output choice, new_game, input board, turn, illegal, game_over, winner);
    modport slave  (input choice, new_game, output board, turn, illegal, game_over, winner);
endinterface

// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller: tic-tac-toe move validation, turn sequencing and win/draw detection.
// Defining TTT_TIMEOUT_EN adds a per-turn forfeit timer of TIMEOUT_CYCLES clocks.
module ttt_turn_controller #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    ttt_turn_controller_if.slave bus
);
    typedef enum logic [1:0] {TURN, CHECK, WIN, DRAW} state_t;
    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d, illegal_q, illegal_d;
    logic [1:0]  winner_q, winner_d;
    logic [3:0]  move_cnt_q, move_cnt_d, prev_choice_q;
    logic [1:0]  c [1:9];
    logic        move_req, valid_cell, cell_ok, line_win;
    logic [3:0]  idx;
    logic [4:0]  bit_idx;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    for (genvar i = 1; i <= 9; i++) begin : g_cell
        assign c[i] = board_q[2*i-2 +: 2];
    end

    function automatic logic same3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] x);
        return (a != 2'b00) && (a == b) && (a == x);
    endfunction

    assign move_req   = (bus.choice != prev_choice_q) && (bus.choice != 4'd0);
    assign valid_cell = (bus.choice >= 4'd1) && (bus.choice <= 4'd9);
    assign idx        = valid_cell ? bus.choice - 4'd1 : 4'd0;
    assign bit_idx    = {idx, 1'b0};
    assign cell_ok    = valid_cell && (board_q[bit_idx +: 2] == 2'b00);
    assign line_win   = same3(c[1], c[2], c[3]) | same3(c[4], c[5], c[6]) | same3(c[7], c[8], c[9]) |
                        same3(c[1], c[4], c[7]) | same3(c[2], c[5], c[8]) | same3(c[3], c[6], c[9]) |
                        same3(c[1], c[5], c[9]) | same3(c[3], c[5], c[7]);

`ifdef TTT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        illegal_d  = 1'b0;
        winner_d   = winner_q;
        move_cnt_d = move_cnt_q;
`ifdef TTT_TIMEOUT_EN
        timer_d    = (state_q == TURN) ? timer_q + 1'b1 : '0;
`endif
        if (bus.new_game) begin
            state_d    = TURN;
            board_d    = '0;
            turn_d     = 1'b0;
            winner_d   = 2'b00;
            move_cnt_d = 4'd0;
`ifdef TTT_TIMEOUT_EN
            timer_d    = '0;
`endif
        end else begin
            case (state_q)
                TURN: begin
                    if (move_req && cell_ok) begin
                        board_d[bit_idx +: 2] = turn_q ? 2'b10 : 2'b01;
                        move_cnt_d            = move_cnt_q + 4'd1;
                        state_d               = CHECK;
`ifdef TTT_TIMEOUT_EN
                        timer_d               = '0;
`endif
                    end else begin
                        illegal_d = move_req;
`ifdef TTT_TIMEOUT_EN
                        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            turn_d  = ~turn_q;
                            timer_d = '0;
                        end
`endif
                    end
                end
                // The board already holds the new move, so any matching line belongs to turn_q.
                CHECK: begin
                    if (line_win) begin
                        state_d  = WIN;
                        winner_d = turn_q ? 2'b10 : 2'b01;
                    end else if (move_cnt_q == 4'd9) begin
                        state_d = DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = TURN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= TURN;
            board_q       <= '0;
            turn_q        <= 1'b0;
            illegal_q     <= 1'b0;
            winner_q      <= 2'b00;
            move_cnt_q    <= 4'd0;
            prev_choice_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            turn_q        <= turn_d;
            illegal_q     <= illegal_d;
            winner_q      <= winner_d;
            move_cnt_q    <= move_cnt_d;
            prev_choice_q <= bus.choice;
        end
    end

`ifdef TTT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`endif

    assign bus.board     = board_q;
    assign bus.turn      = turn_q;
    assign bus.illegal   = illegal_q;
    assign bus.game_over = (state_q == WIN) || (state_q == DRAW);
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_ttt_turn_controller.sv
// tb_ttt_turn_controller: scoreboard bench comparing every post-edge output set
// against a cell-array game model; directed test-plan games plus random play.
module tb_ttt_turn_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ttt_turn_controller_if bus();
    ttt_turn_controller dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [17:0] board;
        logic        turn;
        logic        illegal;
        logic        game_over;
        logic [1:0]  winner;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int checks = 0;
    int failures = 0;

    int cells[9];
    int cnt, tur, win, prev;
    bit pending, over, ill;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit has_line();
        for (int l = 0; l < 8; l++) begin
            int a = cells[lines[l][0]];
            if (a != 0 && cells[lines[l][1]] == a && cells[lines[l][2]] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < 9; i++) o.board[2*i +: 2] = 2'(cells[i]);
        o.turn      = tur[0];
        o.illegal   = ill;
        o.game_over = over;
        o.winner    = 2'(win);
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) cells[i] = 0;
        cnt = 0; tur = 0; win = 0; pending = 0; over = 0; ill = 0;
    endtask

    task automatic step(input logic [3:0] c, input logic ng);
        bit req;
        req  = (c != 4'(prev)) && (c != 0);
        prev = int'(c);
        ill  = 0;
        if (ng) model_clear();
        else if (over) ;
        else if (pending) begin
            pending = 0;
            if (has_line()) begin over = 1; win = tur + 1; end
            else if (cnt == 9) begin over = 1; win = 0; end
            else tur ^= 1;
        end else if (req) begin
            if (c > 9 || cells[c-1] != 0) ill = 1;
            else begin cells[c-1] = tur + 1; cnt++; pending = 1; end
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic ng);
        @(negedge clk);
        bus.choice   = c;
        bus.new_game = ng;
        step(c, ng);
        exp_q.push_back(model_obs());
    endtask

    task automatic move(input logic [3:0] c);
        drive(4'd0, 1'b0);
        drive(c, 1'b0);
        drive(c, 1'b0);
    endtask

    task automatic play(input int seq[$]);
        foreach (seq[i]) move(4'(seq[i]));
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = {bus.board, bus.turn, bus.illegal, bus.game_over, bus.winner};
        checks++;
        if (a !== '0) begin
            failures++;
            $display("FAIL %s actual=%h required=0", name, a);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        bus.choice = 4'd0; bus.new_game = 1'b0;
        prev = 0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {bus.board, bus.turn, bus.illegal, bus.game_over, bus.winner};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL obs t=%0t actual board=%h turn=%b illegal=%b over=%b winner=%b required board=%h turn=%b illegal=%b over=%b winner=%b",
                         $time, mon_a.board, mon_a.turn, mon_a.illegal, mon_a.game_over, mon_a.winner,
                         mon_e.board, mon_e.turn, mon_e.illegal, mon_e.game_over, mon_e.winner);
            end
        end
    end

    initial begin
        bus.choice = 4'd0;
        bus.new_game = 1'b0;
        prev = 0;
        model_clear();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b1;
        move(4'd5);
        move(4'd5);
        drive(4'd0, 1'b1);
        play('{1, 4, 2, 5, 3});
        move(4'd9);
        drive(4'd0, 1'b1);
        play('{1, 2, 3, 5, 4, 6, 8, 7, 9});
        move(4'd5);
        drive(4'd0, 1'b1);
        play('{1, 2, 3, 5, 4, 6, 8, 9, 7});
        drive(4'd0, 1'b1);
        drive(4'd0, 1'b0);
        drive(4'd12, 1'b0);
        drive(4'd12, 1'b0);
        drive(4'd0, 1'b1);
        drive(4'd5, 1'b1);
        drive(4'd5, 1'b0);
        move(4'd1);
        move(4'd2);
        async_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 3) == 0) ? bus.choice
              : ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
              : 4'($urandom_range(0, 9));
            drive(c, $urandom_range(0, 63) == 0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
